// File: rtl/router_fifo.sv
// Per-port router output FIFO of {header_flag, byte} entries with packet-length tracking; optional parity check under FIFO_PARITY_CHK_EN.
// Latency: data_out is registered and shows a byte one cycle after read_enb is accepted; full/empty come straight from the pointers.
// Backpressure: a write while full or a read while empty is dropped silently; soft_reset flushes the FIFO like a reset.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef FIFO_PARITY_CHK_EN
    ,
    output logic             parity_err
`endif
);

    // Each entry holds {header_flag, byte}; the extra bit marks a packet header.
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [6:0]       r_pkt_cnt;
    logic [WIDTH-1:0] r_data_out;

    logic             w_full;
    logic             w_empty;
    logic             w_flush;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH:0]   w_rd_entry;
    logic             w_rd_hdr;
    logic [WIDTH-1:0] w_rd_byte;
    logic [6:0]       w_hdr_len;
    logic [AW:0]      w_ptr_one;

    assign w_ptr_one  = {{AW{1'b0}}, 1'b1};

    // The extra wrap bit tells a full FIFO from an empty one when the low bits match.
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_flush    = !resetn || soft_reset;

    // Read and write are each gated by the flags as they stand before the edge.
    assign w_wr_acc   = write_enb && !w_full && !w_flush;
    assign w_rd_acc   = read_enb && !w_empty && !w_flush;

    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd_hdr   = w_rd_entry[WIDTH];
    assign w_rd_byte  = w_rd_entry[WIDTH-1:0];

    // Header byte is {len, addr}; the count left is the payload plus the parity byte.
    assign w_hdr_len  = {1'b0, w_rd_byte[7:2]} + 7'd1;

    assign full       = w_full;
    assign empty      = w_empty;
    assign data_out   = r_data_out;

    // Storage array: no reset, because a flush only moves the pointers.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    // Pointers, packet countdown and the registered read data.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + w_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + w_ptr_one;
                r_data_out <= w_rd_byte;
                if (w_rd_hdr) begin
                    r_pkt_cnt <= w_hdr_len;
                end else if (r_pkt_cnt != 7'd0) begin
                    r_pkt_cnt <= r_pkt_cnt - 7'd1;
                end
            end else if (r_pkt_cnt == 7'd0) begin
                // Between packets the output returns to zero.
                r_data_out <= '0;
            end
        end
    end

`ifdef FIFO_PARITY_CHK_EN
    logic [WIDTH-1:0] r_acc;
    logic             r_parity_err;

    assign parity_err = r_parity_err;

    // XOR accumulator over header and payload, compared against the trailing parity byte.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_acc        <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if (w_rd_acc) begin
                if (w_rd_hdr) begin
                    r_acc <= w_rd_byte;
                end else if (r_pkt_cnt == 7'd1) begin
                    r_parity_err <= (r_acc != w_rd_byte);
                end else if (r_pkt_cnt != 7'd0) begin
                    r_acc <= r_acc ^ w_rd_byte;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: read data checked through an expected-value queue by a separate monitor.
// Latency: the monitor compares data_out on the falling edge after each cycle in which read_enb was sampled high.
// Backpressure: covers writes while full, reads while empty, simultaneous read/write and soft_reset flush.
module tb_router_fifo;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb  = 1'b0;
    logic       lfd_state  = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       read_enb   = 1'b0;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef FIFO_PARITY_CHK_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t exp_q[$];

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
`ifdef FIFO_PARITY_CHK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, release just after the rising edge.
    task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic sr);
        @(negedge clock);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        @(posedge clock);
        #1;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        step(1'b1, lfd, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] d, input logic p);
        push_exp(d, p);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic both(input logic [7:0] din, input logic [7:0] d, input logic p);
        push_exp(d, p);
        step(1'b1, 1'b0, din, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle with read_enb sampled outside reset owes one expected output.
    initial begin
        logic seen;
        exp_t e;
        forever begin
            @(posedge clock);
            seen = read_enb && resetn && !soft_reset;
            @(negedge clock);
            if (seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got data_out %0h with no expected entry", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", {24'h0, data_out}, {24'h0, e.d});
`ifdef FIFO_PARITY_CHK_EN
                    chk("rd_parity_err", {31'h0, parity_err}, {31'h0, e.p});
`endif
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two clocks.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
`ifdef FIFO_PARITY_CHK_EN
        chk("rst_parity_err", {31'h0, parity_err}, 32'h0);
`endif
        @(negedge clock);
        resetn = 1'b1;

        // Single packet: header 0D (len 3), three payload bytes, parity DF.
        // Header XOR payload is DD, so the DF parity byte is flagged as a mismatch.
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hB2, 1'b0);
        wr(8'hC3, 1'b0);
        wr(8'hDF, 1'b0);
        chk("pkt_not_empty", {31'h0, empty}, 32'h0);
        rd(8'h0D, 1'b0);
        rd(8'hA1, 1'b0);
        rd(8'hB2, 1'b0);
        rd(8'hC3, 1'b0);
        rd(8'hDF, 1'b1);
        chk("pkt_empty", {31'h0, empty}, 32'h1);
        idle();
        chk("pkt_idle_zero", {24'h0, data_out}, 32'h0);

        // Fill to 16, the 17th write is dropped, then drain in order.
        for (int i = 0; i < 17; i++) begin
            wr(8'(i), 1'b0);
            if (i == 14) chk("fill_not_full_15", {31'h0, full}, 32'h0);
            if (i == 15) chk("fill_full_16", {31'h0, full}, 32'h1);
        end
        chk("fill_full_17", {31'h0, full}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            rd(8'(i), 1'b0);
        end
        chk("drain_empty", {31'h0, empty}, 32'h1);
        chk("drain_not_full", {31'h0, full}, 32'h0);

        // Read+write at full: only the read happens.
        for (int i = 0; i < 16; i++) begin
            wr(8'h20 + 8'(i), 1'b0);
        end
        chk("rw_full_before", {31'h0, full}, 32'h1);
        both(8'h55, 8'h20, 1'b0);
        chk("rw_full_after", {31'h0, full}, 32'h0);
        // Drain down to a level of 5 (0x2B..0x2F remain).
        for (int i = 1; i < 11; i++) begin
            rd(8'h20 + 8'(i), 1'b0);
        end
        // Read+write at level 5: level unchanged, order preserved.
        both(8'h60, 8'h2B, 1'b0);
        chk("rw_mid_not_empty", {31'h0, empty}, 32'h0);
        chk("rw_mid_not_full", {31'h0, full}, 32'h0);
        rd(8'h2C, 1'b0);
        rd(8'h2D, 1'b0);
        rd(8'h2E, 1'b0);
        rd(8'h2F, 1'b0);
        chk("rw_mid_level1", {31'h0, empty}, 32'h0);
        rd(8'h60, 1'b0);
        chk("rw_mid_empty", {31'h0, empty}, 32'h1);

        // Soft reset in the middle of a packet.
        wr(8'h09, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        rd(8'h09, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("sr_empty", {31'h0, empty}, 32'h1);
        chk("sr_data_out", {24'h0, data_out}, 32'h0);
        rd(8'h00, 1'b0);
        chk("sr_read_empty", {31'h0, empty}, 32'h1);

        // Packet 09,11,22 with wrong parity 00 (correct is 3A), then with correct parity.
        wr(8'h09, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h00, 1'b0);
        rd(8'h09, 1'b0);
        rd(8'h11, 1'b0);
        rd(8'h22, 1'b0);
        rd(8'h00, 1'b1);
        idle();
        chk("perr_idle_data", {24'h0, data_out}, 32'h0);
`ifdef FIFO_PARITY_CHK_EN
        chk("perr_one_cycle", {31'h0, parity_err}, 32'h0);
`endif
        wr(8'h09, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h3A, 1'b0);
        rd(8'h09, 1'b0);
        rd(8'h11, 1'b0);
        rd(8'h22, 1'b0);
        rd(8'h3A, 1'b0);
        idle();
        chk("good_idle_data", {24'h0, data_out}, 32'h0);

        idle();
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
